alu_cmd_arbiter: RTL and testbench
==================================

# alu_cmd_arbiter

Two-requester round-robin arbiter and sequencer for the shared ALU datapath (InA/InB/Sel operands). Sits between the command front-ends (key-unlocked command port and register-file access path) and the single ALU instance. Accepts one operation at a time, drives the ALU with a start pulse, waits for its done, and returns the result to the owning requester. Keeps a completed-operation counter for status readback.

## Interface
- DATA_W, 8, operand width (InA/InB equivalent)
- SEL_W, 4, ALU opcode width
- TIMEOUT, 32, max cycles spent in WAIT before forced completion (used only with the timeout feature)

- Clk  in  1  single clock; all state updates on rising edge
- Reset  in  1  asynchronous, active-low reset
- Req0, Req1  in  1  operation request; held high until matching Gnt
- A0, A1, B0, B1  in  DATA_W  operands, valid while Req high
- Sel0, Sel1  in  SEL_W  opcode, valid while Req high
- Gnt0, Gnt1  out  1  one-cycle pulse: request accepted, operands captured
- Done0, Done1  out  1  one-cycle pulse: Result valid for that requester
- Result  out  2*DATA_W  result of last completed operation; held until next completion
- Err  out  1  one-cycle pulse coincident with Done on timeout (0 when feature compiled out)
- Busy  out  1  high in every state except IDLE
- OpCount  out  8  completed-operation count
- AluStart  out  1  one-cycle start to ALU
- AluA, AluB  out  DATA_W  captured operands, stable from AluStart until next grant
- AluSel  out  SEL_W  captured opcode
- AluDone  in  1  ALU completion pulse
- AluOut  in  2*DATA_W  ALU result, valid when AluDone high

## Operation
- States: IDLE, ISSUE, WAIT, RESP. Reset state IDLE.
- Reset (Reset low, any time incl. mid-operation): state IDLE; all outputs 0 (Gnt*, Done*, Err, Busy, AluStart, AluA/B/Sel, Result, OpCount); Owner=0; LastGnt=1. In-flight operation discarded; no Done issued for it.
- IDLE: if no Req, stay. If exactly one Req, grant it. If both: grant the requester not equal to LastGnt (after reset Req0 wins). On grant: capture A/B/Sel of winner into AluA/AluB/AluSel, Owner<=winner, LastGnt<=winner, GntX<=1, AluStart<=1, -> ISSUE.
- ISSUE: Gnt and AluStart high this cycle only; -> WAIT. AluDone ignored in ISSUE.
- WAIT: on AluDone: Result<=AluOut, Done[Owner]<=1, OpCount<=OpCount+1, -> RESP. Otherwise stay.
- RESP: Done high this cycle; -> IDLE unconditionally. Requests not sampled in RESP.
- Req of the owning requester after Gnt is ignored until IDLE; a request held across completion is treated as a new operation.
- Req of the losing requester stays pending; round-robin guarantees it wins the next IDLE arbitration.
- OpCount wraps 255 -> 0, modulo 256; timed-out operations also count.
- Result width 2*DATA_W, passed through unmodified; no arithmetic in this block besides OpCount.

## Timing
- All outputs registered.
- Req sampled high in IDLE at edge k -> Gnt, AluStart, AluA/B/Sel valid in cycle k..k+1; Busy high from edge k.
- AluDone earliest sampled at edge k+2; AluDone sampled at edge m -> Done, Result, OpCount updated after edge m; back in IDLE after edge m+1; next grant earliest at edge m+2.
- Overhead per op: 3 cycles + ALU latency (ALU latency L cycles after AluStart -> Done L+1 cycles after Gnt).
- Back-to-back contention: alternating grants, no starvation.

## Configuration
- ALU_ARB_TIMEOUT_EN defined: 8-bit-or-wider counter clears on WAIT entry, increments each WAIT cycle; when it reaches TIMEOUT with no AluDone: Result<=all ones, Done[Owner]<=1, Err<=1, OpCount increments, -> RESP. AluDone arriving the same edge as expiry takes priority (normal completion, Err=0).
- Not defined: no counter; WAIT holds indefinitely until AluDone; Err tied 0.

## Test plan
- Reset, Req0 with A0=0x01, B0=0x05, Sel0=0x0, ALU model latency 3 returning 0x0006 -> Gnt0 pulse one cycle after request, AluA=0x01/AluB=0x05, Done0 with Result=0x0006, OpCount=1, Gnt1/Done1 never high.
- Req0 and Req1 asserted same cycle after reset (A0=0x06,B0=0x06; A1=0x02,B1=0x03) -> Req0 served first, then Req1; next simultaneous pair -> Req1 first? no: Req0 (LastGnt=1); alternating across 4 ops.
- Reset asserted low in WAIT -> all outputs 0 immediately, no Done; after release, pending Req1 granted normally, OpCount restarts at 1.
- ALU_ARB_TIMEOUT_EN, TIMEOUT=16, AluDone never asserted -> Done0 and Err high together 16 cycles after WAIT entry, Result=0xFFFF; without macro Busy stays high, no Done.
- 256 consecutive Req1 ops -> OpCount 255 then 0; every op returns correct Result; Busy low only in IDLE cycles.
- AluDone pulsed during ISSUE only -> ignored, block stays in WAIT until next AluDone.

Source files
------------

// File: rtl/alu_cmd_arbiter.sv
// Two-requester round-robin arbiter/sequencer in front of a single shared ALU.
// Optional WAIT watchdog enabled by defining ALU_ARB_TIMEOUT_EN.
module alu_cmd_arbiter #(
    parameter int DATA_W  = 8,
    parameter int SEL_W   = 4,
    parameter int TIMEOUT = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_req0,
    input  logic                  i_req1,
    input  logic [DATA_W-1:0]     i_a0,
    input  logic [DATA_W-1:0]     i_a1,
    input  logic [DATA_W-1:0]     i_b0,
    input  logic [DATA_W-1:0]     i_b1,
    input  logic [SEL_W-1:0]      i_sel0,
    input  logic [SEL_W-1:0]      i_sel1,
    output logic                  o_gnt0,
    output logic                  o_gnt1,
    output logic                  o_done0,
    output logic                  o_done1,
    output logic [2*DATA_W-1:0]   o_result,
    output logic                  o_err,
    output logic                  o_busy,
    output logic [7:0]            o_op_count,
    output logic                  o_alu_start,
    output logic [DATA_W-1:0]     o_alu_a,
    output logic [DATA_W-1:0]     o_alu_b,
    output logic [SEL_W-1:0]      o_alu_sel,
    input  logic                  i_alu_done,
    input  logic [2*DATA_W-1:0]   i_alu_out
);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_t;

    state_t              r_state;
    logic                r_owner;
    logic                r_last_gnt;
    logic                r_gnt0, r_gnt1, r_done0, r_done1, r_busy, r_alu_start;
    logic [2*DATA_W-1:0] r_result;
    logic [7:0]          r_op_count;
    logic [DATA_W-1:0]   r_alu_a, r_alu_b;
    logic [SEL_W-1:0]    r_alu_sel;
    logic                w_pick1;
    logic                w_expire;

    // Requester 1 wins if it is alone, or if both ask and requester 0 won last time.
    assign w_pick1 = i_req1 & (~i_req0 | ~r_last_gnt);

`ifdef ALU_ARB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    logic [CNT_W-1:0] r_tmo_cnt;
    logic             r_err;

    assign w_expire = (r_tmo_cnt == CNT_W'(TIMEOUT - 1));
    assign o_err    = r_err;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tmo_cnt <= '0;
            r_err     <= 1'b0;
        end else begin
            if (r_state == ST_ISSUE) begin
                r_tmo_cnt <= '0;
            end else if (r_state == ST_WAIT) begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end
            // Err only when the watchdog fires without a coincident AluDone.
            r_err <= (r_state == ST_WAIT) && w_expire && !i_alu_done;
        end
    end
`else
    logic [31:0] w_unused_timeout;
    assign w_unused_timeout = 32'(TIMEOUT);
    assign w_expire         = 1'b0;
    assign o_err            = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_owner     <= 1'b0;
            r_last_gnt  <= 1'b1;
            r_gnt0      <= 1'b0;
            r_gnt1      <= 1'b0;
            r_done0     <= 1'b0;
            r_done1     <= 1'b0;
            r_busy      <= 1'b0;
            r_alu_start <= 1'b0;
            r_result    <= '0;
            r_op_count  <= '0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_sel   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_req0 || i_req1) begin
                        r_owner     <= w_pick1;
                        r_last_gnt  <= w_pick1;
                        r_gnt0      <= ~w_pick1;
                        r_gnt1      <= w_pick1;
                        r_alu_start <= 1'b1;
                        r_busy      <= 1'b1;
                        r_alu_a     <= w_pick1 ? i_a1   : i_a0;
                        r_alu_b     <= w_pick1 ? i_b1   : i_b0;
                        r_alu_sel   <= w_pick1 ? i_sel1 : i_sel0;
                        r_state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_gnt0      <= 1'b0;
                    r_gnt1      <= 1'b0;
                    r_alu_start <= 1'b0;
                    r_state     <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (i_alu_done || w_expire) begin
                        r_result   <= i_alu_done ? i_alu_out : '1;
                        r_done0    <= ~r_owner;
                        r_done1    <= r_owner;
                        r_op_count <= r_op_count + 8'd1;
                        r_state    <= ST_RESP;
                    end
                end
                default: begin
                    r_done0 <= 1'b0;
                    r_done1 <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_gnt0      = r_gnt0;
    assign o_gnt1      = r_gnt1;
    assign o_done0     = r_done0;
    assign o_done1     = r_done1;
    assign o_result    = r_result;
    assign o_busy      = r_busy;
    assign o_op_count  = r_op_count;
    assign o_alu_start = r_alu_start;
    assign o_alu_a     = r_alu_a;
    assign o_alu_b     = r_alu_b;
    assign o_alu_sel   = r_alu_sel;

endmodule

// File: tb/tb_alu_cmd_arbiter.sv
// Directed bench for alu_cmd_arbiter: vector table of single operations plus
// hand sequences for ISSUE-phase AluDone, mid-WAIT reset, watchdog and counter wrap.
module tb_alu_cmd_arbiter;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_req0 = 1'b0, i_req1 = 1'b0;
    logic [7:0]  i_a0 = '0, i_a1 = '0, i_b0 = '0, i_b1 = '0;
    logic [3:0]  i_sel0 = '0, i_sel1 = '0;
    logic        i_alu_done = 1'b0;
    logic [15:0] i_alu_out = '0;
    logic        o_gnt0, o_gnt1, o_done0, o_done1, o_err, o_busy, o_alu_start;
    logic [15:0] o_result;
    logic [7:0]  o_op_count, o_alu_a, o_alu_b;
    logic [3:0]  o_alu_sel;

    int checks = 0;
    int failures = 0;

    alu_cmd_arbiter #(.DATA_W(8), .SEL_W(4), .TIMEOUT(16)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_req0(i_req0), .i_req1(i_req1),
        .i_a0(i_a0), .i_a1(i_a1), .i_b0(i_b0), .i_b1(i_b1),
        .i_sel0(i_sel0), .i_sel1(i_sel1),
        .o_gnt0(o_gnt0), .o_gnt1(o_gnt1), .o_done0(o_done0), .o_done1(o_done1),
        .o_result(o_result), .o_err(o_err), .o_busy(o_busy), .o_op_count(o_op_count),
        .o_alu_start(o_alu_start), .o_alu_a(o_alu_a), .o_alu_b(o_alu_b), .o_alu_sel(o_alu_sel),
        .i_alu_done(i_alu_done), .i_alu_out(i_alu_out)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        req0;
        logic        req1;
        logic [7:0]  a0;
        logic [7:0]  b0;
        logic [3:0]  sel0;
        logic [7:0]  a1;
        logic [7:0]  b1;
        logic [3:0]  sel1;
        int          lat;
        logic [15:0] alu_out;
        logic        win;
        logic [7:0]  cnt;
    } vec_t;

    vec_t vecs[8];

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_flags"}, 32'({o_gnt0, o_gnt1, o_done0, o_done1, o_err, o_busy, o_alu_start}), 32'd0);
        chk({name, "_alu"}, 32'({o_alu_a, o_alu_b, o_alu_sel}), 32'd0);
        chk({name, "_result"}, 32'(o_result), 32'd0);
        chk({name, "_opcount"}, 32'(o_op_count), 32'd0);
    endtask

    // One full operation from IDLE: request, grant, ALU completion, response, back to IDLE.
    task automatic run_op(input vec_t v, input int idx);
        logic [7:0] exp_a, exp_b;
        logic [3:0] exp_sel;
        exp_a   = v.win ? v.a1 : v.a0;
        exp_b   = v.win ? v.b1 : v.b0;
        exp_sel = v.win ? v.sel1 : v.sel0;
        i_req0 = v.req0; i_req1 = v.req1;
        i_a0 = v.a0; i_b0 = v.b0; i_sel0 = v.sel0;
        i_a1 = v.a1; i_b1 = v.b1; i_sel1 = v.sel1;
        tick();
        chk("gnt0", 32'(o_gnt0), 32'(!v.win));
        chk("gnt1", 32'(o_gnt1), 32'(v.win));
        chk("alu_start", 32'(o_alu_start), 32'd1);
        chk("busy_grant", 32'(o_busy), 32'd1);
        chk("alu_a", 32'(o_alu_a), 32'(exp_a));
        chk("alu_b", 32'(o_alu_b), 32'(exp_b));
        chk("alu_sel", 32'(o_alu_sel), 32'(exp_sel));
        if (v.win) i_req1 = 1'b0; else i_req0 = 1'b0;
        repeat (v.lat) tick();
        chk("no_early_done", 32'({o_done0, o_done1}), 32'd0);
        chk("alu_start_low", 32'(o_alu_start), 32'd0);
        i_alu_done = 1'b1;
        i_alu_out  = v.alu_out;
        tick();
        i_alu_done = 1'b0;
        i_alu_out  = 16'hDEAD;
        chk("done0", 32'(o_done0), 32'(!v.win));
        chk("done1", 32'(o_done1), 32'(v.win));
        chk("result", 32'(o_result), 32'(v.alu_out));
        chk("opcount", 32'(o_op_count), 32'(v.cnt));
        chk("err_normal", 32'(o_err), 32'd0);
        chk("busy_resp", 32'(o_busy), 32'd1);
        tick();
        chk("done_cleared", 32'({o_done0, o_done1}), 32'd0);
        chk("busy_idle", 32'(o_busy), 32'd0);
        chk("result_held", 32'(o_result), 32'(v.alu_out));
        $display("op %0d: winner=%0d a=%02h b=%02h sel=%0h result=%04h opcount=%0d",
                 idx, v.win, exp_a, exp_b, exp_sel, o_result, o_op_count);
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        #1;
        chk_all_zero("reset");
        tick();
        tick();
        i_rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        bit   seen;
        int   n;
        logic err_at_done;
        logic [15:0] res_at_done;

        vecs[0] = '{1'b1, 1'b1, 8'h06, 8'h06, 4'h2, 8'h02, 8'h03, 4'h2, 2, 16'h0024, 1'b0, 8'd1};
        vecs[1] = '{1'b1, 1'b1, 8'h06, 8'h06, 4'h2, 8'h02, 8'h03, 4'h2, 2, 16'h0006, 1'b1, 8'd2};
        vecs[2] = '{1'b1, 1'b1, 8'h10, 8'h10, 4'h2, 8'h02, 8'h03, 4'h2, 1, 16'h0100, 1'b0, 8'd3};
        vecs[3] = '{1'b1, 1'b1, 8'h10, 8'h10, 4'h2, 8'hFF, 8'hFF, 4'h2, 5, 16'hFE01, 1'b1, 8'd4};
        vecs[4] = '{1'b1, 1'b0, 8'h01, 8'h05, 4'h0, 8'h00, 8'h00, 4'h0, 3, 16'h0006, 1'b0, 8'd5};
        vecs[5] = '{1'b0, 1'b1, 8'h00, 8'h00, 4'h0, 8'h80, 8'h7F, 4'h3, 1, 16'h00FF, 1'b1, 8'd6};
        vecs[6] = '{1'b1, 1'b0, 8'hAA, 8'h55, 4'h5, 8'h11, 8'h22, 4'h1, 4, 16'hA5A5, 1'b0, 8'd7};
        vecs[7] = '{1'b1, 1'b1, 8'h03, 8'h04, 4'h2, 8'h07, 8'h09, 4'h2, 2, 16'h003F, 1'b1, 8'd8};

        do_reset();
        chk_all_zero("after_reset");

        for (int i = 0; i < 8; i++) run_op(vecs[i], i);

        // AluDone during ISSUE must be ignored.
        i_req0 = 1'b1; i_req1 = 1'b0;
        tick();
        chk("issue_gnt0", 32'(o_gnt0), 32'd1);
        i_req0 = 1'b0;
        i_alu_done = 1'b1; i_alu_out = 16'hBAD0;
        tick();
        i_alu_done = 1'b0;
        repeat (3) tick();
        chk("issue_done_ignored", 32'({o_done0, o_done1}), 32'd0);
        chk("issue_still_busy", 32'(o_busy), 32'd1);
        chk("issue_opcount_same", 32'(o_op_count), 32'd8);
        i_alu_done = 1'b1; i_alu_out = 16'h0F0F;
        tick();
        i_alu_done = 1'b0;
        chk("issue_real_done0", 32'(o_done0), 32'd1);
        chk("issue_real_result", 32'(o_result), 32'h0F0F);
        chk("issue_real_opcount", 32'(o_op_count), 32'd9);
        tick();
        $display("op issue-phase-done: result=%04h opcount=%0d", o_result, o_op_count);

        // Reset in WAIT discards the operation; a pending Req1 is served afterwards.
        i_req0 = 1'b1;
        tick();
        chk("rstw_gnt0", 32'(o_gnt0), 32'd1);
        i_req0 = 1'b0; i_req1 = 1'b1;
        tick();
        tick();
        chk("rstw_req1_not_granted", 32'(o_gnt1), 32'd0);
        do_reset();
        v = '{1'b0, 1'b1, 8'h00, 8'h00, 4'h0, 8'h21, 8'h43, 4'h7, 2, 16'h1357, 1'b1, 8'd1};
        run_op(v, 100);

        // Watchdog: no AluDone at all.
        i_req0 = 1'b1; i_req1 = 1'b0;
        tick();
        chk("tmo_gnt0", 32'(o_gnt0), 32'd1);
        i_req0 = 1'b0;
        seen = 1'b0; n = 0; err_at_done = 1'b0; res_at_done = '0;
        for (int i = 1; i <= 40 && !seen; i++) begin
            tick();
            if (o_done0) begin
                seen = 1'b1; n = i; err_at_done = o_err; res_at_done = o_result;
            end
        end
`ifdef ALU_ARB_TIMEOUT_EN
        chk("tmo_seen", 32'(seen), 32'd1);
        chk("tmo_latency", 32'(n), 32'd17);
        chk("tmo_err", 32'(err_at_done), 32'd1);
        chk("tmo_result", 32'(res_at_done), 32'hFFFF);
        chk("tmo_opcount", 32'(o_op_count), 32'd2);
        tick();
        chk("tmo_err_cleared", 32'(o_err), 32'd0);
        chk("tmo_idle", 32'(o_busy), 32'd0);
`else
        chk("notmo_no_done", 32'(seen), 32'd0);
        chk("notmo_busy", 32'(o_busy), 32'd1);
        chk("notmo_err", 32'(o_err), 32'd0);
        i_alu_done = 1'b1; i_alu_out = 16'h1234;
        tick();
        i_alu_done = 1'b0;
        chk("notmo_done0", 32'(o_done0), 32'd1);
        chk("notmo_result", 32'(o_result), 32'h1234);
        chk("notmo_opcount", 32'(o_op_count), 32'd2);
        tick();
        chk("notmo_idle", 32'(o_busy), 32'd0);
`endif
        $display("op watchdog: done_seen=%0d after %0d cycles result=%04h", seen, n, o_result);

        // 256 back-to-back Req1 operations: OpCount goes 255 then wraps to 0.
        do_reset();
        for (int i = 1; i <= 256; i++) begin
            v.req0 = 1'b0; v.req1 = 1'b1;
            v.a0 = 8'h00; v.b0 = 8'h00; v.sel0 = 4'h0;
            v.a1 = 8'(i); v.b1 = 8'(i * 3); v.sel1 = 4'(i);
            v.lat = 1 + (i % 3);
            v.alu_out = {8'(i), ~8'(i)};
            v.win = 1'b1;
            v.cnt = 8'(i);
            run_op(v, 200 + i);
        end
        chk("wrap_final", 32'(o_op_count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
